scan_mux_n: RTL and testbench
=============================

// Module: scan_mux_n
// PURPOSE
//  Parametrised N:1 channel selector with a registered output. Successor to the
//  fixed 4:1 combinational mux. Adds a configurable channel count and width,
//  plus three modes: MANUAL select, AUTO round-robin scan with a programmable
//  dwell time and a channel skip mask, and HOLD. Sits between ui_in/uio_in
//  channel inputs and uo_out in the TT tile top.
// PARAMETERS
//  NCH      4               number of input channels (>=2)
//  W        1               bits per channel
//  SELW     $clog2(NCH)     select width (derived, do not override)
//  DWELL_W  8               width of the dwell-count input
// PORTS
//  clk      in   1          clock
//  rst      in   1          synchronous reset, active-high
//  mode     in   2          00 MANUAL, 01 AUTO, 10 HOLD, 11 HOLD (reserved)
//  sel_in   in   SELW       channel requested in MANUAL mode
//  dwell    in   DWELL_W    cycles spent on each channel in AUTO (0 acts as 1)
//  mask     in   NCH        1 = channel enabled for AUTO scan; ignored in MANUAL
//  din      in   NCH*W      channel k occupies din[k*W +: W]
//  dout     out  W          registered selected data
//  cur_sel  out  SELW       channel currently driving dout
//  wrap     out  1          one-cycle pulse when AUTO scan passes NCH-1 -> 0
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): cur_sel=0, dout=0, wrap=0, dwell counter=0.
//    rst takes priority over every other input. Reset mid-scan aborts the scan.
//  - Coherence: cur_sel and dout update on the same edge.
//    dout <= din[next_sel*W +: W], where din is sampled at that edge.
//    Latency is 1 cycle in every non-HOLD mode.
//  - MANUAL: next_sel = sel_in.
//    If sel_in >= NCH (non-power-of-2 NCH), cur_sel holds its value.
//    dout still reloads from din[cur_sel]. wrap=0.
//  - AUTO: the dwell counter increments every cycle. eff = (dwell==0) ? 1 : dwell.
//    When counter >= eff-1:
//      * counter <= 0.
//      * cur_sel advances to the next channel with mask=1, searching circularly
//        from cur_sel+1.
//      * wrap=1 for that cycle if the search crossed NCH-1 -> 0.
//    Otherwise cur_sel holds and dout reloads din[cur_sel] every cycle.
//    dwell is compared live; lowering it below the current count advances on
//    the next edge.
//  - AUTO mask cases:
//      * Exactly one bit set: advance lands on the same channel and wrap pulses
//        once per dwell period.
//      * mask==0: cur_sel holds, wrap=0, counter keeps running, dout keeps
//        tracking din[cur_sel].
//      * Current channel masked: it is still held until the dwell expires.
//  - Entering AUTO from any other mode clears the dwell counter.
//    The first advance occurs eff cycles after entry.
//  - HOLD (10/11): cur_sel, dout and the counter are frozen; wrap=0.
//    Leaving HOLD for AUTO clears the counter, per the rule above.
//  - Only mode/sel_in/dwell/mask/din values present at an edge matter;
//    no combinational input-to-output paths.
// TESTING
//  1 Reset: drive rst=1 for 2 cycles with din=4'hF -> dout=0, cur_sel=0, wrap=0.
//  2 MANUAL, NCH=4, W=1, din=4'b1010: sel_in 0,1,2,3 on consecutive edges
//    -> dout 0,1,0,1 and cur_sel 0,1,2,3, each one cycle after its sel_in.
//  3 AUTO, dwell=3, mask=4'hF -> cur_sel 0,0,0,1,1,1,2,2,2,3,3,3,0.
//    wrap is high only in the cycle cur_sel returns to 0.
//    Also check dwell=0 -> cur_sel advances every cycle.
//  4 AUTO, dwell=1, mask=4'b1010 -> cur_sel 1,3,1,3 and wrap on each 3->1 step.
//    Then mask=0 -> cur_sel frozen, wrap=0.
//  5 HOLD mid-scan at cur_sel=2 for 5 cycles while din toggles
//    -> dout and cur_sel constant.
//    Return to AUTO with dwell=2 -> first advance 2 cycles later.
//  6 MANUAL with NCH=3 and sel_in=3 -> cur_sel holds its previous value.
//    Assert rst during AUTO -> cur_sel=0 on the next edge.

Source files
------------

// File: rtl/scan_mux_n_if.sv
// Channel-selector bus: mode/select/scan controls and channel data in,
// registered selected data and scan status out.
interface scan_mux_n_if #(
  parameter int NCH     = 4,
  parameter int W       = 1,
  parameter int DWELL_W = 8
);
  localparam int SELW = $clog2(NCH);

  logic [1:0]         mode;
  logic [SELW-1:0]    sel_in;
  logic [DWELL_W-1:0] dwell;
  logic [NCH-1:0]     mask;
  logic [NCH*W-1:0]   din;
  logic [W-1:0]       dout;
  logic [SELW-1:0]    cur_sel;
  logic               wrap;

  modport master (
    output mode, sel_in, dwell, mask, din,
    input  dout, cur_sel, wrap
  );

  modport slave (
    input  mode, sel_in, dwell, mask, din,
    output dout, cur_sel, wrap
  );
endinterface

// File: rtl/scan_mux_n.sv
// Parametrised N:1 channel selector with registered output.
// Modes: MANUAL select, AUTO round-robin scan with dwell time and skip mask,
// HOLD (freeze). cur_sel and dout always update together.
module scan_mux_n #(
  parameter int NCH     = 4,
  parameter int W       = 1,
  parameter int DWELL_W = 8
) (
  input logic         clk,
  input logic         rst,
  scan_mux_n_if.slave bus
);
  localparam int SELW = $clog2(NCH);
  localparam int unsigned NCH_U = NCH;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_HOLD_R = 2'b11
  } mode_t;

  logic [SELW-1:0]    r_cur_sel;
  logic [W-1:0]       r_dout;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_was_auto;

  mode_t              w_mode;
  logic               w_sel_ok;
  logic [DWELL_W-1:0] w_eff;
  logic [DWELL_W-1:0] w_cnt_eff;
  logic               w_expire;
  logic               w_found;
  logic [SELW-1:0]    w_adv_sel;
  logic               w_adv_wrap;
  logic [SELW-1:0]    w_next_sel;
  logic [W-1:0]       w_mux;

  assign w_mode    = mode_t'(bus.mode);
  assign w_sel_ok  = ({1'b0, bus.sel_in} < (SELW+1)'(NCH));
  assign w_eff     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  // A counter left over from an earlier AUTO stint counts as zero on re-entry.
  assign w_cnt_eff = r_was_auto ? r_cnt : '0;
  assign w_expire  = (w_cnt_eff >= (w_eff - DWELL_W'(1)));

  // Circular search for the next enabled channel, starting at cur_sel+1.
  always_comb begin
    int unsigned idx;
    logic        bit_en;
    w_found    = 1'b0;
    w_adv_sel  = r_cur_sel;
    w_adv_wrap = 1'b0;
    idx        = 0;
    bit_en     = 1'b0;
    for (int unsigned k = 1; k <= NCH_U; k++) begin
      idx    = (32'(r_cur_sel) + k) % NCH_U;
      bit_en = 1'b0;
      for (int unsigned j = 0; j < NCH_U; j++) begin
        if (j == idx) bit_en = bus.mask[j];
      end
      if (!w_found && bit_en) begin
        w_found    = 1'b1;
        w_adv_sel  = SELW'(idx);
        w_adv_wrap = ((32'(r_cur_sel) + k) >= NCH_U);
      end
    end
  end

  // Channel that will drive dout after the coming edge.
  always_comb begin
    w_next_sel = r_cur_sel;
    case (w_mode)
      MODE_MANUAL: if (w_sel_ok) w_next_sel = bus.sel_in;
      MODE_AUTO:   if (w_expire && w_found) w_next_sel = w_adv_sel;
      default:     w_next_sel = r_cur_sel;
    endcase
  end

  // Data mux on the next selection so dout and cur_sel stay coherent.
  always_comb begin
    w_mux = '0;
    for (int unsigned k = 0; k < NCH_U; k++) begin
      if (SELW'(k) == w_next_sel) w_mux = bus.din[k*W +: W];
    end
  end

  // Selection, data, dwell counter and wrap pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_sel  <= '0;
      r_dout     <= '0;
      r_wrap     <= 1'b0;
      r_cnt      <= '0;
      r_was_auto <= 1'b0;
    end else begin
      case (w_mode)
        MODE_MANUAL: begin
          r_cur_sel  <= w_next_sel;
          r_dout     <= w_mux;
          r_wrap     <= 1'b0;
          r_cnt      <= '0;
          r_was_auto <= 1'b0;
        end
        MODE_AUTO: begin
          r_cur_sel  <= w_next_sel;
          r_dout     <= w_mux;
          r_was_auto <= 1'b1;
          if (w_expire) begin
            r_cnt  <= '0;
            r_wrap <= w_found && w_adv_wrap;
          end else begin
            r_cnt  <= w_cnt_eff + DWELL_W'(1);
            r_wrap <= 1'b0;
          end
        end
        default: begin
          r_wrap     <= 1'b0;
          r_was_auto <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout    = r_dout;
  assign bus.cur_sel = r_cur_sel;
  assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_scan_mux_n.sv
// Directed self-checking bench for scan_mux_n (NCH=4 and NCH=3 instances).
module tb_scan_mux_n;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  scan_mux_n_if #(.NCH(4), .W(1), .DWELL_W(8)) b0 ();
  scan_mux_n_if #(.NCH(3), .W(1), .DWELL_W(8)) b1 ();

  scan_mux_n #(.NCH(4), .W(1), .DWELL_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(b0.slave));
  scan_mux_n #(.NCH(3), .W(1), .DWELL_W(8)) u_dut3 (.clk(clk), .rst(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned exp_sel;
    logic [3:0] t4_sel [4];
    logic       t4_wrap [4];
    t4_sel  = '{4'd1, 4'd3, 4'd1, 4'd3};
    t4_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    b0.mode = 2'b00; b0.sel_in = 2'd3; b0.dwell = 8'd0; b0.mask = 4'hF; b0.din = 4'hF;
    b1.mode = 2'b00; b1.sel_in = 2'd2; b1.dwell = 8'd0; b1.mask = 3'b111; b1.din = 3'b111;

    // Reset
    step(); step();
    check("rst_cur", 32'(b0.cur_sel), 0);
    check("rst_dout", 32'(b0.dout), 0);
    check("rst_wrap", 32'(b0.wrap), 0);
    check("rst_cur3", 32'(b1.cur_sel), 0);

    // MANUAL sweep, din=1010
    rst = 1'b0;
    b0.din = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      b0.sel_in = 2'(i);
      step();
      check("man_cur", 32'(b0.cur_sel), 32'(i));
      check("man_dout", 32'(b0.dout), 32'(i % 2));
      check("man_wrap", 32'(b0.wrap), 0);
    end
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_cur", 32'(b0.cur_sel), 0);

    // AUTO dwell=3, all channels
    b0.mode = 2'b01; b0.dwell = 8'd3; b0.mask = 4'hF;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_sel = ((i + 1) / 3) % 4;
      check("auto3_cur", 32'(b0.cur_sel), exp_sel);
      check("auto3_wrap", 32'(b0.wrap), (i == 11) ? 1 : 0);
      check("auto3_dout", 32'(b0.dout), exp_sel % 2);
    end

    // AUTO dwell=0 advances every cycle
    b0.dwell = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("auto0_cur", 32'(b0.cur_sel), 32'((i + 1) % 4));
      check("auto0_wrap", 32'(b0.wrap), (i == 3) ? 1 : 0);
    end

    // AUTO dwell=1, mask=1010
    b0.dwell = 8'd1; b0.mask = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("skip_cur", 32'(b0.cur_sel), 32'(t4_sel[i]));
      check("skip_wrap", 32'(b0.wrap), 32'(t4_wrap[i]));
    end

    // mask=0: frozen selection, dout still tracks din[cur_sel]
    b0.mask = 4'b0000; b0.din = 4'b0111;
    step();
    check("m0_cur", 32'(b0.cur_sel), 3);
    check("m0_wrap", 32'(b0.wrap), 0);
    check("m0_dout", 32'(b0.dout), 0);
    b0.din = 4'b1000;
    step();
    check("m0_cur2", 32'(b0.cur_sel), 3);
    check("m0_dout2", 32'(b0.dout), 1);
    step();
    check("m0_wrap2", 32'(b0.wrap), 0);

    // Walk to channel 2 then HOLD while din toggles
    b0.mask = 4'hF; b0.din = 4'b1010;
    step();
    check("walk_cur0", 32'(b0.cur_sel), 0);
    check("walk_wrap", 32'(b0.wrap), 1);
    step(); step();
    check("walk_cur2", 32'(b0.cur_sel), 2);
    check("walk_dout", 32'(b0.dout), 0);
    for (int i = 0; i < 5; i++) begin
      b0.mode = (i < 3) ? 2'b10 : 2'b11;
      b0.din  = (i % 2 == 1) ? 4'b1010 : 4'b0101;
      step();
      check("hold_cur", 32'(b0.cur_sel), 2);
      check("hold_dout", 32'(b0.dout), 0);
      check("hold_wrap", 32'(b0.wrap), 0);
    end

    // Back to AUTO, dwell=2: first advance on the second edge
    b0.mode = 2'b01; b0.dwell = 8'd2; b0.din = 4'b1010;
    step();
    check("reent_cur1", 32'(b0.cur_sel), 2);
    step();
    check("reent_cur2", 32'(b0.cur_sel), 3);
    check("reent_dout", 32'(b0.dout), 1);

    // Reset during AUTO
    rst = 1'b1;
    step();
    check("rstauto_cur", 32'(b0.cur_sel), 0);
    check("rstauto_dout", 32'(b0.dout), 0);
    check("rstauto_wrap", 32'(b0.wrap), 0);
    rst = 1'b0;

    // NCH=3: out-of-range select holds cur_sel but reloads dout
    b1.mode = 2'b00; b1.sel_in = 2'd1; b1.din = 3'b100;
    step();
    check("n3_cur", 32'(b1.cur_sel), 1);
    check("n3_dout", 32'(b1.dout), 0);
    b1.sel_in = 2'd3;
    step();
    check("n3_oor_cur", 32'(b1.cur_sel), 1);
    b1.din = 3'b010;
    step();
    check("n3_oor_cur2", 32'(b1.cur_sel), 1);
    check("n3_oor_dout", 32'(b1.dout), 1);

    // NCH=3 AUTO wrap 2 -> 0
    b1.mode = 2'b01; b1.dwell = 8'd0; b1.mask = 3'b111;
    step();
    check("n3_auto_cur", 32'(b1.cur_sel), 2);
    check("n3_auto_wrap0", 32'(b1.wrap), 0);
    step();
    check("n3_wrap_cur", 32'(b1.cur_sel), 0);
    check("n3_wrap", 32'(b1.wrap), 1);
    check("n3_wrap_dout", 32'(b1.dout), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
